// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST controller.
// LFSR taps are for the 21-bit x^21+x^19+1 Fibonacci generator.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          LFSR_TAP_HI  = 20;
  localparam int          LFSR_TAP_LO  = 18;
  localparam logic [9:0]  MISR_MASK    = 10'h009;
  localparam logic [20:0] DEFAULT_SEED = 21'h000001;

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register: shift left, fold the top bit back through MASK,
// xor in the parallel data word. Clear has priority over enable.
module gate_bist_misr
  import gate_bist_pkg::*;
#(
  parameter int           W    = 10,
  parameter logic [W-1:0] MASK = W'(MISR_MASK)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? MASK : '0) ^ data;
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller for one combinational gate model: LFSR pattern source, settle and
// pattern counters, MISR compaction and golden-signature compare.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int              IN_W   = 21,
  parameter int              OUT_W  = 10,
  parameter int              N_PAT  = 200,
  parameter int              SETTLE = 1,
  parameter logic [IN_W-1:0] SEED   = IN_W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [OUT_W-1:0] golden_i,
  output logic [IN_W-1:0]  pattern_o,
  input  logic [OUT_W-1:0] response_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [OUT_W-1:0] signature_o,
  output state_t           state_o
);

  localparam int              PW          = $clog2(N_PAT + 1);
  localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW-1:0]   PAT_LAST    = PW'(N_PAT - 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [IN_W-1:0] SEED_EFF    = (SEED == '0) ? IN_W'(1) : SEED;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   lfsr_q;
  logic [PW-1:0]     pat_q;
  logic [SW-1:0]     settle_q;
  logic [OUT_W-1:0]  golden_q;
  logic              busy_q, done_q;
  logic              start_run, stop_run, step, finish;
  logic              fb;

  assign fb = lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO];

  // start_i is a level sampled only in IDLE/DONE; abort_i is sampled only in RUN and wins.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    stop_run  = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d  = ST_IDLE;
          stop_run = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          step = 1'b1;
          if (pat_q == PAT_LAST) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The LFSR register doubles as the pattern output, so it is zeroed whenever not running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q   <= '0;
      pat_q    <= '0;
      settle_q <= '0;
      golden_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start_run) begin
      lfsr_q   <= SEED_EFF;
      pat_q    <= '0;
      settle_q <= '0;
      golden_q <= golden_i;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (stop_run) begin
      lfsr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (finish) begin
      lfsr_q   <= '0;
      pat_q    <= pat_q + PW'(1);
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b1;
    end else if (step) begin
      lfsr_q   <= {lfsr_q[IN_W-2:0], fb};
      pat_q    <= pat_q + PW'(1);
      settle_q <= '0;
    end else if (state_q == ST_RUN) begin
      settle_q <= settle_q + SW'(1);
    end
  end

  gate_bist_misr #(
    .W    (OUT_W),
    .MASK (OUT_W'(MISR_MASK))
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_run),
    .en   (step),
    .data (response_i),
    .sig  (signature_o)
  );

  assign pattern_o = lfsr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = done_q & (signature_o == golden_q);
  assign state_o   = state_q;

endmodule
